mux_nx1_reg_64: RTL

Parametrised, registered N:1 word multiplexer with a valid/ready handshake and a two-entry output skid buffer. It generalises the 2:1 64-bit combinational state mux in the round-based PRESENT datapath. Typical use: choosing between plaintext load, round-function output, and bypass/debug sources for the state register, without stalling the upstream when the round datapath applies back-pressure.

---
 rtl/mux_nx1_reg_64_if.sv | 27 ++
 rtl/mux_nx1_reg_64.sv | 83 ++++++++
 2 files changed

// File: rtl/mux_nx1_reg_64_if.sv
// Handshake bundle for mux_nx1_reg_64: flattened input channels with select, plus registered output.
// The master side drives the word/select pair and out_ready; the slave side is the mux itself.
interface mux_nx1_reg_64_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_flat;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  modport master (
    output in_flat, sel, in_valid, out_ready,
    input  in_ready, out, out_valid, sel_err
  );

  modport slave (
    input  in_flat, sel, in_valid, out_ready,
    output in_ready, out, out_valid, sel_err
  );
endinterface

// File: rtl/mux_nx1_reg_64.sv
// Registered N:1 word mux with valid/ready handshake and a two-entry skid buffer.
// Out-of-range selects still complete as a zero word and raise a one-cycle sel_err.
module mux_nx1_reg_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
) (
  input logic               clk,
  input logic               rst,
  mux_nx1_reg_64_if.slave   bus
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;

  logic             accept, pop, in_range;
  logic [WIDTH-1:0] word;

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = (count_q != 2'd0) && bus.out_ready;

  // Channel decode; an unmatched select leaves the word at zero.
  always_comb begin
    word     = '0;
    in_range = (32'(bus.sel) < N);
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(bus.sel) == k) begin
        word = bus.in_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = word;
        end else begin
          tail_d = word;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Accept with pop only happens at count 1 since a full buffer deasserts in_ready.
      2'b11: head_d = word;
      default: ;
    endcase
    in_ready_d = (count_d != 2'd2) && !rst;
    sel_err_d  = accept && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = (count_q != 2'd0);
    bus.out       = (count_q != 2'd0) ? head_q : '0;
    bus.sel_err   = sel_err_q;
  end

endmodule
